fetch_seq: RTL and testbench
============================

# fetch_seq

Instruction fetch and stage sequencer for the multi-cycle core. It holds the program counter and fetches the instruction word from instruction memory through a request/acknowledge handshake. It registers the word as `instr_raw` and drives the 3-bit `state` code (FETCH=0, DECODE=1, EXEC=2, MEM=3, WRITE=4) that every other stage, including decode, qualifies on. At the end of WRITE it computes the next PC from the branch controls and results produced downstream.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.
- `clk` input 1: single clock; all state updates on posedge.
- `rst` input 1: asynchronous, active-high reset.
- `imem_req` output 1: instruction memory request.
- `imem_addr` output 32: fetch address; equals `pc`.
- `imem_ack` input 1: memory has valid data on `imem_rdata` this cycle.
- `imem_rdata` input 32: instruction word.
- `branch_uc` input 1: unconditional jump (jal/jalr), valid from EXEC onward.
- `branch_c` input 1: conditional branch (bge), valid from EXEC onward.
- `jump_reg` input 1: jump target is register-relative (jalr).
- `cond` input 1: branch condition result (ALU ge output bit 0).
- `imm` input 32: decoded immediate.
- `alu_result` input 32: ALU result, used as the jalr target.
- `mem_busy` input 1: data memory not finished; holds MEM.
- `state` output 3: current stage code.
- `instr_raw` output 32: latched instruction.
- `pc` output 32: address of the current instruction.
- `pc_plus4` output 32: `pc + 4`, the link value for jal/jalr.
- `halt` output 1: core stopped (see Configuration).

## Operation
- FSM states: FETCH(0), DECODE(1), EXEC(2), MEM(3), WRITE(4). Codes 5–7 are illegal and go to FETCH on the next edge.
- **FETCH:** `imem_req`=1 and `imem_addr`=`pc` for every cycle in FETCH with `imem_ack` low.
  - On the first cycle with `imem_ack`=1: `instr_raw` <= `imem_rdata`, `imem_req` drops to 0 on the next cycle, and the FSM goes to DECODE.
  - Acks outside FETCH are ignored.
- **DECODE, EXEC:** one cycle each, no conditions.
- **MEM:** stays while `mem_busy`=1; goes to WRITE on the first cycle with `mem_busy`=0.
- **WRITE:** one cycle. On exit, `pc` <= next_pc and the FSM goes to FETCH.
- **next_pc priority:**
  - `branch_uc && jump_reg`: `alu_result & ~32'h1`.
  - `branch_uc`: `pc + imm`.
  - `branch_c && cond`: `pc + imm`.
  - otherwise: `pc + 4`.
- All address arithmetic is 32-bit modulo 2^32; wrap from 32'hFFFF_FFFC to 0 is silent.
- `instr_raw` holds from FETCH exit until the next FETCH completes, so decode always sees a stable word.
- **Halted:** when `halt`=1, the FSM stays in FETCH with `imem_req`=0. Only `rst` clears `halt`.

## Timing
- **Reset values:** `state`=0, `pc`=`RESET_PC`, `instr_raw`=0, `imem_req`=0, `halt`=0.
  - `imem_req` rises on the first posedge after `rst` deasserts.
  - `pc_plus4`=`RESET_PC`+4 (combinational from `pc`).
- **Latency:** minimum instruction length is 5 cycles (ack in the first FETCH cycle, `mem_busy`=0); each wait cycle adds 1.
- **Ack timing:** ack on cycle N of FETCH gives `state`=1 and a valid `instr_raw` at cycle N+1.
- **Sampling:** branch inputs are sampled only in the WRITE cycle; their values in other states are don't-care.
- **Reset mid-operation:** `rst` asserted in any state, including mid-handshake, immediately forces the reset values. A late `imem_ack` arriving after reset is ignored unless the FSM is in FETCH.

## Configuration
- **Macro:** `FETCH_MISALIGN_TRAP_EN`.
- **Defined:** if next_pc[1:0] != 0 at WRITE exit, `pc` is not updated, `halt` <= 1, and the FSM enters FETCH without asserting `imem_req`.
- **Undefined:** next_pc[1:0] is forced to 0 before it is loaded into `pc`, and `halt` is tied to 0.

## Test plan
- **Reset and sequential fetch:** reset with `RESET_PC`=0x100, ack in the first FETCH cycle, no branches -> `imem_addr` 0x100, then 0x104, then 0x108; `state` sequence 0,1,2,3,4,0 at 5 cycles per instruction; `instr_raw` matches `imem_rdata`.
- **Wait states:** ack delayed 3 cycles and `mem_busy` high 2 cycles -> `imem_req` held 4 cycles with a constant address, MEM lasts 3 cycles, 10 cycles total.
- **Branches** with `pc`=0x200 and `imm`=0x40:
  - jal -> next fetch at 0x240.
  - `branch_c` with `cond`=0 -> 0x204.
  - `branch_c` with `cond`=1 -> 0x240.
  - jalr with `alu_result`=0x1235 -> 0x1234.
- **Priority:** `branch_uc` and `branch_c`/`cond` asserted together with `jump_reg`=1 -> the jalr target wins.
- **Reset mid-FETCH:** assert `rst` with `imem_req` high and the ack pending -> all outputs return to reset values asynchronously; the ack pulse that follows is ignored until FETCH resumes.
- **Misaligned target:** jalr to 0x1002:
  - with `FETCH_MISALIGN_TRAP_EN` defined -> `halt`=1, `pc` unchanged, no further `imem_req`.
  - without the macro -> next fetch at 0x1000.

Source files
------------

// File: rtl/fetch_seq.sv
// fetch_seq: program counter, instruction fetch handshake and the five-stage sequencer
// (FETCH/DECODE/EXEC/MEM/WRITE). Optional FETCH_MISALIGN_TRAP_EN halts on a misaligned next PC.
module fetch_seq #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        branch_uc,
    input  logic        branch_c,
    input  logic        jump_reg,
    input  logic        cond,
    input  logic [31:0] imm,
    input  logic [31:0] alu_result,
    input  logic        mem_busy,
    output logic [2:0]  state,
    output logic [31:0] instr_raw,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        halt
);

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WRITE  = 3'd4
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic        req_q, req_d;
    logic        halted_d;
    logic [31:0] target;

    // Branch target; only consumed in WRITE, so the controls are don't-care elsewhere.
    always_comb begin
        target = pc_q + 32'd4;
        if (branch_uc && jump_reg) begin
            target = alu_result & ~32'h1;
        end else if (branch_uc || (branch_c && cond)) begin
            target = pc_q + imm;
        end
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    logic halt_q, halt_d;
`endif

    // Handshake: imem_req is registered and held high with imem_addr stable for every FETCH
    // cycle until imem_ack; an ack counts only while req is high in FETCH, so acks in other
    // states, in the first cycle after reset, or while halted are ignored.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
`ifdef FETCH_MISALIGN_TRAP_EN
        halt_d  = halt_q;
`endif
        case (state_q)
            ST_FETCH: begin
                if (req_q && imem_ack) begin
                    instr_d = imem_rdata;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: state_d = ST_EXEC;
            ST_EXEC:   state_d = ST_MEM;
            ST_MEM: begin
                if (!mem_busy) begin
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                state_d = ST_FETCH;
`ifdef FETCH_MISALIGN_TRAP_EN
                if (target[1:0] != 2'b00) begin
                    halt_d = 1'b1;
                end else begin
                    pc_d = target;
                end
`else
                pc_d = target & ~32'h3;
`endif
            end
            default: state_d = ST_FETCH;
        endcase
`ifdef FETCH_MISALIGN_TRAP_EN
        halted_d = halt_d;
`else
        halted_d = 1'b0;
`endif
        req_d = (state_d == ST_FETCH) && !halted_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_FETCH;
            pc_q    <= RESET_PC;
            instr_q <= 32'h0;
            req_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            req_q   <= req_d;
        end
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            halt_q <= 1'b0;
        end else begin
            halt_q <= halt_d;
        end
    end
    assign halt = halt_q;
`else
    assign halt = 1'b0;
`endif

    assign state     = state_q;
    assign pc        = pc_q;
    assign pc_plus4  = pc_q + 32'd4;
    assign imem_req  = req_q;
    assign imem_addr = pc_q;
    assign instr_raw = instr_q;

endmodule

// File: tb/tb_fetch_seq.sv
// Bench for fetch_seq: directed branch/reset cases plus randomized instructions checked
// against an arithmetic next-PC model and per-cycle stage expectations.
module tb_fetch_seq;

    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        branch_uc, branch_c, jump_reg, cond;
    logic [31:0] imm, alu_result;
    logic        mem_busy;
    logic [2:0]  state;
    logic [31:0] instr_raw, pc, pc_plus4;
    logic        halt;

    int          tests = 0;
    int          fails = 0;
    logic [31:0] exp_pc;
    logic        exp_halt;
    logic [31:0] saved_pc;

    fetch_seq #(.RESET_PC(RST_PC)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .branch_uc(branch_uc), .branch_c(branch_c), .jump_reg(jump_reg), .cond(cond),
        .imm(imm), .alu_result(alu_result), .mem_busy(mem_busy),
        .state(state), .instr_raw(instr_raw), .pc(pc), .pc_plus4(pc_plus4), .halt(halt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Next PC from the branch rules; bit 32 flags a halt (trap build only).
    function automatic logic [32:0] model(input logic [31:0] cur, input logic buc, bc, jr, cnd,
                                          input logic [31:0] immv, aluv);
        logic [31:0] t;
        if (buc && jr)             t = aluv & ~32'h1;
        else if (buc || (bc && cnd)) t = cur + immv;
        else                       t = cur + 32'd4;
`ifdef FETCH_MISALIGN_TRAP_EN
        if (t[1:0] != 2'b00) return {1'b1, cur};
        return {1'b0, t};
`else
        return {1'b0, t & ~32'h3};
`endif
    endfunction

    task automatic check_reset_values(input string tag);
        chk({tag, "_state"}, 32'(state), 32'd0);
        chk({tag, "_pc"}, pc, RST_PC);
        chk({tag, "_pc_plus4"}, pc_plus4, RST_PC + 32'd4);
        chk({tag, "_instr"}, instr_raw, 32'd0);
        chk({tag, "_req"}, 32'(imem_req), 32'd0);
        chk({tag, "_halt"}, 32'(halt), 32'd0);
    endtask

    // Entered on the first FETCH cycle (req high); returns on the next FETCH cycle.
    task automatic run_instr(input int ack_dly, input int busy, input logic [31:0] word,
                             input logic buc, bc, jr, cnd, input logic [31:0] immv, aluv);
        logic [32:0] m;
        {branch_uc, branch_c, jump_reg, cond} = 4'($urandom);
        imm        = $urandom;
        alu_result = $urandom;
        chk("fetch_state", 32'(state), 32'd0);
        chk("fetch_req", 32'(imem_req), 32'd1);
        chk("fetch_addr", imem_addr, exp_pc);
        chk("pc_plus4", pc_plus4, exp_pc + 32'd4);
        for (int i = 0; i < ack_dly; i++) begin
            imem_ack   = 1'b0;
            imem_rdata = $urandom;
            tick();
            chk("wait_state", 32'(state), 32'd0);
            chk("wait_req", 32'(imem_req), 32'd1);
            chk("wait_addr", imem_addr, exp_pc);
        end
        imem_ack   = 1'b1;
        imem_rdata = word;
        tick();
        imem_rdata = ~word;
        chk("decode_state", 32'(state), 32'd1);
        chk("instr_raw", instr_raw, word);
        chk("req_drop", 32'(imem_req), 32'd0);
        tick();
        imem_ack = 1'b0;
        chk("exec_state", 32'(state), 32'd2);
        chk("instr_hold", instr_raw, word);
        mem_busy = (busy > 0);
        tick();
        chk("mem_state", 32'(state), 32'd3);
        for (int i = 0; i < busy; i++) begin
            mem_busy = (i + 1 < busy);
            tick();
            chk(mem_busy || (i + 1 < busy) ? "mem_busy_state" : "mem_last_state",
                32'(state), (i + 1 < busy) ? 32'd3 : 32'd4);
        end
        mem_busy = 1'b0;
        if (busy == 0) begin
            tick();
            chk("write_state", 32'(state), 32'd4);
        end
        branch_uc  = buc;
        branch_c   = bc;
        jump_reg   = jr;
        cond       = cnd;
        imm        = immv;
        alu_result = aluv;
        m = model(exp_pc, buc, bc, jr, cnd, immv, aluv);
        exp_halt = m[32];
        exp_pc   = m[31:0];
        tick();
        chk("next_state", 32'(state), 32'd0);
        chk("next_pc", pc, exp_pc);
        chk("next_req", 32'(imem_req), 32'(!exp_halt));
        chk("halt", 32'(halt), 32'(exp_halt));
        chk("instr_after", instr_raw, word);
    endtask

    initial begin
        rst = 1'b0;
        imem_ack = 1'b0; imem_rdata = 32'h0; mem_busy = 1'b0;
        branch_uc = 1'b0; branch_c = 1'b0; jump_reg = 1'b0; cond = 1'b0;
        imm = 32'h0; alu_result = 32'h0;
        #1 rst = 1'b1;
        #10;
        check_reset_values("reset");
        chk("reset_addr", imem_addr, RST_PC);
        #2 rst = 1'b0;
        tick();
        chk("req_rise", 32'(imem_req), 32'd1);
        exp_pc = RST_PC;
        exp_halt = 1'b0;

        for (int i = 0; i < 3; i++) begin
            run_instr(0, 0, $urandom, 1'b0, 1'b0, 1'($urandom), 1'($urandom), $urandom, $urandom);
        end
        chk("seq_pc", pc, 32'h10C);
        run_instr(3, 2, $urandom, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

        run_instr(0, 0, $urandom, 1'b1, 1'b0, 1'b1, 1'b0, $urandom, 32'h201);
        chk("to_200", pc, 32'h200);
        run_instr(0, 0, $urandom, 1'b1, 1'b0, 1'b0, 1'b0, 32'h40, $urandom);
        chk("jal", pc, 32'h240);
        run_instr(0, 0, $urandom, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h200);
        run_instr(1, 0, $urandom, 1'b0, 1'b1, 1'b0, 1'b0, 32'h40, $urandom);
        chk("bge_not_taken", pc, 32'h204);
        run_instr(0, 0, $urandom, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h200);
        run_instr(0, 1, $urandom, 1'b0, 1'b1, 1'b0, 1'b1, 32'h40, $urandom);
        chk("bge_taken", pc, 32'h240);
        run_instr(0, 0, $urandom, 1'b1, 1'b0, 1'b1, 1'b0, 32'h40, 32'h1235);
        chk("jalr", pc, 32'h1234);
        run_instr(0, 0, $urandom, 1'b1, 1'b1, 1'b1, 1'b1, 32'h40, 32'h2001);
        chk("priority", pc, 32'h2000);
        run_instr(0, 0, $urandom, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0 - 32'h2000 - 32'h4, $urandom);
        chk("wrap", pc, 32'hFFFF_FFFC);
        run_instr(0, 0, $urandom, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("wrap_zero", pc, 32'h0);

        for (int i = 0; i < 40; i++) begin
            run_instr($urandom_range(0, 3), $urandom_range(0, 3), $urandom,
                      1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                      $urandom & 32'hFFFF_FFFC, $urandom & 32'hFFFF_FFFD);
        end

        imem_ack = 1'b0;
        #3 rst = 1'b1;
        #1;
        check_reset_values("rst_mid");
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        tick();
        rst = 1'b0;
        tick();
        chk("late_ack_state", 32'(state), 32'd0);
        chk("late_ack_instr", instr_raw, 32'd0);
        chk("late_ack_req", 32'(imem_req), 32'd1);
        imem_ack = 1'b0;
        exp_pc = RST_PC;
        run_instr(0, 0, $urandom, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

        saved_pc = exp_pc;
        run_instr(0, 0, $urandom, 1'b1, 1'b0, 1'b1, 1'b0, $urandom, 32'h1002);
`ifdef FETCH_MISALIGN_TRAP_EN
        chk("trap_pc", pc, saved_pc);
        chk("trap_halt", 32'(halt), 32'd1);
        imem_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("halted_req", 32'(imem_req), 32'd0);
            chk("halted_state", 32'(state), 32'd0);
            chk("halted_pc", pc, saved_pc);
            chk("halted_halt", 32'(halt), 32'd1);
        end
        imem_ack = 1'b0;
`else
        chk("misalign_pc", pc, 32'h1000);
        chk("misalign_halt", 32'(halt), 32'd0);
        run_instr(0, 0, $urandom, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("after_misalign", pc, 32'h1004);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
